mem_issue_ctrl: RTL and testbench
=================================

# mem_issue_ctrl

Dequeue-side controller for the memory issue queue: drains ready entries from the mem ISQ and delivers them, one per cycle, to the load/store unit. Issues only entries whose wake-up condition bits are all set, and holds them in a two-entry registered skid buffer so LSU backpressure never reaches the queue combinationally. Drops buffered instructions younger than a flush point, and sits between the mem ISQ dequeue port and the LSU issue port in the backend ISU.

## Interface
- DATA_WIDTH, 248, width of the issued instruction payload
- CONDITION_WIDTH, 2, wake-up condition bits per entry; issue requires all ones
- ISQID_WIDTH, 4, width of the queue self-id (clog2(DEPTH)+1 for DEPTH 8)
- ROBID_LSB, 0, bit position of the robid field (width `ROB_SIZE_LOG+1`) inside the payload
- clock  input  1  sole clock
- reset  input  1  asynchronous, active-high reset
- deq_valid  input  1  mem ISQ head valid
- deq_ready  output  1  accept head this cycle
- deq_data  input  DATA_WIDTH  head payload
- deq_condition  input  CONDITION_WIDTH  head wake-up bits
- deq_isqid  input  ISQID_WIDTH  head self-id
- flush_valid  input  1  pipeline flush
- flush_robid  input  `ROB_SIZE_LOG+1  flush point; MSB is the wrap bit
- issue_valid  output  1  instruction offered to the LSU
- issue_ready  input  1  LSU accepts
- issue_data  output  DATA_WIDTH  payload
- issue_isqid  output  ISQID_WIDTH  self-id of the issued entry

## Operation
- Dequeue fire = deq_valid & deq_ready.
- deq_ready = (deq_condition == all ones) & !flush_valid & (state != FULL).
- Issue fire = issue_valid & issue_ready.
- Storage: out register (drives issue_*) and skid register; out always holds the older entry.
- States:
  - EMPTY: 0 entries.
  - HALF: out valid.
  - FULL: out and skid valid.
- EMPTY: dequeue fire -> HALF, entry loads out.
- HALF: dequeue and issue -> HALF, new entry loads out. Dequeue only -> FULL, new entry loads skid. Issue only -> EMPTY.
- FULL: no dequeue. Issue -> HALF, skid moves to out.
- Age compare: entry is younger than flush_robid when the wrap bits are equal and entry idx > flush idx, or the wrap bits differ and entry idx < flush idx. An equal robid is not younger and is kept.
- Flush: at the edge, every valid entry younger than flush_robid is invalidated.
  - Only skid killed -> HALF.
  - Both killed -> EMPTY.
  - Out killed implies skid killed.
- During flush_valid, issue_valid is masked combinationally if out is younger, so a killed entry never fires.
- A surviving out entry may fire in the flush cycle.

## Timing
- Latency: dequeue fire at cycle N -> issue_valid at N+1 (registered); throughput is 1 per cycle sustained.
- issue_valid and issue_data stay stable while issue_ready is low; they never depend combinationally on issue_ready.
- deq_ready depends combinationally on deq_condition and flush_valid only, never on issue_ready.
- Reset, asynchronous and active-high:
  - State is EMPTY, issue_valid=0, issue_data=0, issue_isqid=0.
  - deq_ready=0 while reset is asserted.
  - Reset mid-transfer discards all buffered entries.
- Flush and dequeue in the same cycle: the dequeue is blocked (deq_ready=0); the queue flushes itself.

## Configuration
- MEM_ISSUE_PERF_EN defined:
  - Adds 32-bit outputs perf_issue_cnt (issue fires) and perf_stall_cnt (cycles with issue_valid & !issue_ready).
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- MEM_ISSUE_PERF_EN undefined: ports and counters are absent and behaviour is otherwise identical.

## Structure
- Shared backend package holds:
  - the robid age-compare function (is_younger)
  - the state enum (EMPTY/HALF/FULL)
  - the robid width constant derived from `ROB_SIZE_LOG.
- Sub-module mem_issue_skid: the two-entry skid register pair with per-entry kill inputs. The top level keeps the FSM, the condition gating and the flush age compare.

## Test plan
- Condition gating: head valid, condition 2'b01 for 3 cycles, then 2'b11 -> deq_ready=0 for 3 cycles; fire on cycle 4; issue_valid on cycle 5.
- Backpressure: stream 4 ready entries with issue_ready=0 -> two accepted (FULL), deq_ready=0. Release issue_ready -> entries issue in order, one per cycle, none lost or duplicated.
- Flush partial: FULL with out robid 5, skid robid 7, flush_robid 6 (same wrap) -> skid dropped, state HALF, robid 5 still issues.
- Flush wrap: out robid {1,2}, flush_robid {0,30} with ROB_SIZE_LOG=5 -> out is younger, killed; issue_valid low in the flush cycle; state EMPTY.
- Flush equal robid: out robid 9, flush_robid 9 -> kept; issue fires in the flush cycle if issue_ready=1.
- Async reset mid-stream while FULL -> issue_valid=0 immediately, without waiting for a clock edge; after release, first new dequeue issues one cycle later.

Source files
------------

// File: rtl/mem_issue_ctrl_pkg.sv
// Shared backend definitions for the mem issue path: robid width, dequeue FSM states, robid age compare.
// ROB_SIZE_LOG defaults to 5 when the build does not supply it.
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 5
`endif

package mem_issue_ctrl_pkg;

  localparam int ROBID_W = `ROB_SIZE_LOG + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } issue_state_e;

  // The wrap bit toggles on every ROB rollover, so differing wrap bits invert the index order.
  function automatic logic is_younger(input logic [ROBID_W-1:0] entry_robid,
                                      input logic [ROBID_W-1:0] flush_robid);
    logic [ROBID_W-2:0] e_idx;
    logic [ROBID_W-2:0] f_idx;
    e_idx = entry_robid[ROBID_W-2:0];
    f_idx = flush_robid[ROBID_W-2:0];
    if (entry_robid[ROBID_W-1] == flush_robid[ROBID_W-1]) begin
      is_younger = (e_idx > f_idx);
    end else begin
      is_younger = (e_idx < f_idx);
    end
  endfunction

endpackage

// File: rtl/mem_issue_skid.sv
// Two-entry registered skid pair (out + skid); out always holds the older entry, kills clear per entry.
// Latency: push lands in a register, visible next cycle; pop/kill take effect at the edge.
module mem_issue_skid
  import mem_issue_ctrl_pkg::*;
#(
  parameter int ENTRY_WIDTH = 252,
  parameter int ROBID_LSB   = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   kill_out,
  input  logic                   kill_skid,
  input  logic [ENTRY_WIDTH-1:0] push_dat,
  output logic                   out_vld,
  output logic [ENTRY_WIDTH-1:0] out_dat,
  output logic [ROBID_W-1:0]     skid_robid
);

  logic                   out_vld_q, out_vld_d;
  logic                   skid_vld_q, skid_vld_d;
  logic [ENTRY_WIDTH-1:0] out_dat_q, out_dat_d;
  logic [ENTRY_WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic                   out_live, skid_live;

  always_comb begin
    out_live   = out_vld_q & ~kill_out;
    skid_live  = skid_vld_q & ~kill_skid;
    out_vld_d  = out_live;
    skid_vld_d = skid_live;
    out_dat_d  = out_dat_q;
    skid_dat_d = skid_dat_q;
    if (pop) begin
      if (skid_live) begin
        out_dat_d  = skid_dat_q;
        skid_vld_d = 1'b0;
      end else if (push) begin
        out_dat_d = push_dat;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (push) begin
      // A new entry is always younger than a surviving out entry, so it queues behind it.
      if (out_live) begin
        skid_dat_d = push_dat;
        skid_vld_d = 1'b1;
      end else begin
        out_dat_d = push_dat;
        out_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_dat_q  <= '0;
      skid_dat_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      out_dat_q  <= out_dat_d;
      skid_dat_q <= skid_dat_d;
    end
  end

  assign out_vld    = out_vld_q;
  assign out_dat    = out_dat_q;
  assign skid_robid = skid_dat_q[ROBID_LSB +: ROBID_W];

endmodule

// File: rtl/mem_issue_ctrl.sv
// Mem ISQ dequeue -> LSU issue controller: condition-gated dequeue, 1-cycle registered issue, flush kill.
// LSU backpressure absorbed by a 2-entry skid pair; MEM_ISSUE_PERF_EN adds saturating perf counters.
module mem_issue_ctrl
  import mem_issue_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = 248,
  parameter int CONDITION_WIDTH = 2,
  parameter int ISQID_WIDTH     = 4,
  parameter int ROBID_LSB       = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       deq_valid,
  output logic                       deq_ready,
  input  logic [DATA_WIDTH-1:0]      deq_data,
  input  logic [CONDITION_WIDTH-1:0] deq_condition,
  input  logic [ISQID_WIDTH-1:0]     deq_isqid,
  input  logic                       flush_valid,
  input  logic [ROBID_W-1:0]         flush_robid,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [DATA_WIDTH-1:0]      issue_data,
  output logic [ISQID_WIDTH-1:0]     issue_isqid
`ifdef MEM_ISSUE_PERF_EN
  ,
  output logic [31:0]                perf_issue_cnt,
  output logic [31:0]                perf_stall_cnt
`endif
);

  localparam int ENTRY_W = ISQID_WIDTH + DATA_WIDTH;

  issue_state_e         state_q, state_d;
  logic                 out_vld;
  logic [ENTRY_W-1:0]   out_dat;
  logic [ROBID_W-1:0]   skid_robid;
  logic                 kill_out, kill_skid;
  logic                 out_keep, skid_keep;
  logic                 deq_fire, issue_fire;
  logic [1:0]           live_cnt;

  always_comb begin
    kill_out  = flush_valid & (state_q != EMPTY) &
                is_younger(out_dat[ROBID_LSB +: ROBID_W], flush_robid);
    kill_skid = flush_valid & (state_q == FULL) & is_younger(skid_robid, flush_robid);
    out_keep  = (state_q != EMPTY) & ~kill_out;
    skid_keep = (state_q == FULL) & ~kill_skid;
  end

  // A flush blocks the dequeue: the ISQ drops its own younger entries in the same cycle.
  assign deq_ready   = ~reset & ~flush_valid & (&deq_condition) & (state_q != FULL);
  assign deq_fire    = deq_valid & deq_ready;
  assign issue_valid = out_vld & ~kill_out;
  assign issue_fire  = issue_valid & issue_ready;
  assign issue_data  = out_dat[DATA_WIDTH-1:0];
  assign issue_isqid = out_dat[ENTRY_W-1 -: ISQID_WIDTH];

  always_comb begin
    live_cnt = 2'(out_keep) + 2'(skid_keep) + 2'(deq_fire) - 2'(issue_fire);
    case (live_cnt)
      2'd0:    state_d = EMPTY;
      2'd1:    state_d = HALF;
      default: state_d = FULL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  mem_issue_skid #(
    .ENTRY_WIDTH (ENTRY_W),
    .ROBID_LSB   (ROBID_LSB)
  ) u_skid (
    .clock      (clock),
    .reset      (reset),
    .push       (deq_fire),
    .pop        (issue_fire),
    .kill_out   (kill_out),
    .kill_skid  (kill_skid),
    .push_dat   ({deq_isqid, deq_data}),
    .out_vld    (out_vld),
    .out_dat    (out_dat),
    .skid_robid (skid_robid)
  );

`ifdef MEM_ISSUE_PERF_EN
  logic [31:0] perf_issue_cnt_q, perf_issue_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

  always_comb begin
    perf_issue_cnt_d = perf_issue_cnt_q;
    perf_stall_cnt_d = perf_stall_cnt_q;
    if (issue_fire && (perf_issue_cnt_q != 32'hFFFF_FFFF)) begin
      perf_issue_cnt_d = perf_issue_cnt_q + 32'd1;
    end
    if (issue_valid && !issue_ready && (perf_stall_cnt_q != 32'hFFFF_FFFF)) begin
      perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_issue_cnt_q <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_issue_cnt_q <= perf_issue_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_issue_cnt = perf_issue_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_issue_ctrl.sv
// Directed bench for mem_issue_ctrl: gating, backpressure, flush age cases and async reset.
module tb_mem_issue_ctrl;
  import mem_issue_ctrl_pkg::*;

  localparam int DW = 248;
  localparam int CW = 2;
  localparam int IW = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic               deq_valid;
  logic               deq_ready;
  logic [DW-1:0]      deq_data;
  logic [CW-1:0]      deq_condition;
  logic [IW-1:0]      deq_isqid;
  logic               flush_valid;
  logic [ROBID_W-1:0] flush_robid;
  logic               issue_valid;
  logic               issue_ready;
  logic [DW-1:0]      issue_data;
  logic [IW-1:0]      issue_isqid;
`ifdef MEM_ISSUE_PERF_EN
  logic [31:0]        perf_issue_cnt;
  logic [31:0]        perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_issue_ctrl #(
    .DATA_WIDTH      (DW),
    .CONDITION_WIDTH (CW),
    .ISQID_WIDTH     (IW),
    .ROBID_LSB       (0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .deq_valid     (deq_valid),
    .deq_ready     (deq_ready),
    .deq_data      (deq_data),
    .deq_condition (deq_condition),
    .deq_isqid     (deq_isqid),
    .flush_valid   (flush_valid),
    .flush_robid   (flush_robid),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_data    (issue_data),
    .issue_isqid   (issue_isqid)
`ifdef MEM_ISSUE_PERF_EN
    ,
    .perf_issue_cnt(perf_issue_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  function automatic logic [DW-1:0] mk(input logic [7:0] tag, input logic [ROBID_W-1:0] rob);
    logic [DW-1:0] p;
    p = '0;
    p[ROBID_W-1:0] = rob;
    p[15:8] = tag;
    p[DW-1 -: 8] = ~tag;
    return p;
  endfunction

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [CW-1:0] c, input logic [7:0] tag,
                     input logic [ROBID_W-1:0] rob, input logic [IW-1:0] id);
    deq_valid     = v;
    deq_condition = c;
    deq_data      = mk(tag, rob);
    deq_isqid     = id;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    flush_valid = 1'b0;
    flush_robid = '0;
    issue_ready = 1'b0;
    drv(1'b1, 2'b11, 8'h01, 6'd0, 4'd0);

    // reset state
    #3;
    chk_b("rst_issue_valid", issue_valid, 1'b0);
    chk_d("rst_issue_data", issue_data, '0);
    chk_i("rst_issue_isqid", issue_isqid, 4'd0);
    chk_b("rst_deq_ready", deq_ready, 1'b0);

    // condition gating
    @(negedge clock);
    reset = 1'b0;
    drv(1'b1, 2'b01, 8'h11, 6'd3, 4'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_b("gate_blocked", deq_ready, 1'b0);
      step();
    end
    deq_condition = 2'b11;
    #1;
    chk_b("gate_ready", deq_ready, 1'b1);
    chk_b("gate_no_issue_yet", issue_valid, 1'b0);
    step();
    deq_valid = 1'b0;
    chk_b("gate_issue_valid", issue_valid, 1'b1);
    chk_d("gate_issue_data", issue_data, mk(8'h11, 6'd3));
    chk_i("gate_issue_isqid", issue_isqid, 4'd1);
    issue_ready = 1'b1;
    step();
    chk_b("gate_drained", issue_valid, 1'b0);
    issue_ready = 1'b0;

    // backpressure: two accepted, then in-order release
    drv(1'b1, 2'b11, 8'h20, 6'd10, 4'd2);
    #1;
    chk_b("bp_acc0", deq_ready, 1'b1);
    step();
    drv(1'b1, 2'b11, 8'h21, 6'd11, 4'd3);
    #1;
    chk_b("bp_acc1", deq_ready, 1'b1);
    step();
    drv(1'b1, 2'b11, 8'h22, 6'd12, 4'd4);
    #1;
    chk_b("bp_full_block", deq_ready, 1'b0);
    chk_d("bp_hold0", issue_data, mk(8'h20, 6'd10));
    step();
    chk_b("bp_full_block2", deq_ready, 1'b0);
    chk_b("bp_hold_valid", issue_valid, 1'b1);
    chk_d("bp_hold1", issue_data, mk(8'h20, 6'd10));
    issue_ready = 1'b1;
    #1;
    chk_i("bp_e0_isqid", issue_isqid, 4'd2);
    chk_b("bp_e0_deq_block", deq_ready, 1'b0);
    step();
    #1;
    chk_d("bp_e1", issue_data, mk(8'h21, 6'd11));
    chk_i("bp_e1_isqid", issue_isqid, 4'd3);
    chk_b("bp_half_ready", deq_ready, 1'b1);
    step();
    drv(1'b1, 2'b11, 8'h23, 6'd13, 4'd5);
    #1;
    chk_d("bp_e2", issue_data, mk(8'h22, 6'd12));
    chk_i("bp_e2_isqid", issue_isqid, 4'd4);
    chk_b("bp_e2_ready", deq_ready, 1'b1);
    step();
    deq_valid = 1'b0;
    #1;
    chk_b("bp_e3_valid", issue_valid, 1'b1);
    chk_d("bp_e3", issue_data, mk(8'h23, 6'd13));
    chk_i("bp_e3_isqid", issue_isqid, 4'd5);
    step();
    #1;
    chk_b("bp_empty", issue_valid, 1'b0);
    issue_ready = 1'b0;

    // flush partial: skid robid 7 younger than 6, out robid 5 kept
    drv(1'b1, 2'b11, 8'h30, 6'd5, 4'd6);
    step();
    drv(1'b1, 2'b11, 8'h31, 6'd7, 4'd7);
    step();
    drv(1'b1, 2'b11, 8'h32, 6'd8, 4'd8);
    flush_valid = 1'b1;
    flush_robid = 6'd6;
    #1;
    chk_b("fp_out_valid", issue_valid, 1'b1);
    chk_b("fp_deq_block", deq_ready, 1'b0);
    step();
    flush_valid = 1'b0;
    deq_valid   = 1'b0;
    #1;
    chk_b("fp_half_ready", deq_ready, 1'b1);
    chk_d("fp_out_data", issue_data, mk(8'h30, 6'd5));
    issue_ready = 1'b1;
    step();
    chk_b("fp_skid_gone", issue_valid, 1'b0);
    issue_ready = 1'b0;

    // flush across wrap: out {1,2} younger than {0,30}
    drv(1'b1, 2'b11, 8'h40, 6'h22, 4'd9);
    step();
    deq_valid   = 1'b0;
    flush_valid = 1'b1;
    flush_robid = 6'h1E;
    issue_ready = 1'b1;
    #1;
    chk_b("fw_masked", issue_valid, 1'b0);
    step();
    flush_valid = 1'b0;
    #1;
    chk_b("fw_killed", issue_valid, 1'b0);
    chk_b("fw_empty_ready", deq_ready, 1'b1);
    issue_ready = 1'b0;

    // flush at equal robid keeps the entry; it fires in the flush cycle
    drv(1'b1, 2'b11, 8'h50, 6'd9, 4'd10);
    step();
    drv(1'b1, 2'b11, 8'h51, 6'd10, 4'd11);
    flush_valid = 1'b1;
    flush_robid = 6'd9;
    issue_ready = 1'b1;
    #1;
    chk_b("fe_kept", issue_valid, 1'b1);
    chk_d("fe_data", issue_data, mk(8'h50, 6'd9));
    chk_b("fe_deq_block", deq_ready, 1'b0);
    step();
    flush_valid = 1'b0;
    deq_valid   = 1'b0;
    #1;
    chk_b("fe_fired", issue_valid, 1'b0);
    issue_ready = 1'b0;

    // async reset while FULL
    drv(1'b1, 2'b11, 8'h60, 6'd1, 4'd12);
    step();
    drv(1'b1, 2'b11, 8'h61, 6'd2, 4'd13);
    step();
    deq_valid = 1'b0;
    #1;
    chk_b("ar_pre_valid", issue_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk_b("ar_valid_now", issue_valid, 1'b0);
    chk_d("ar_data_now", issue_data, '0);
    chk_b("ar_deq_ready", deq_ready, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    drv(1'b1, 2'b11, 8'h62, 6'd3, 4'd14);
    #1;
    chk_b("ar_post_idle", issue_valid, 1'b0);
    chk_b("ar_post_ready", deq_ready, 1'b1);
    step();
    deq_valid = 1'b0;
    chk_b("ar_new_valid", issue_valid, 1'b1);
    chk_d("ar_new_data", issue_data, mk(8'h62, 6'd3));
    issue_ready = 1'b1;
    step();
    chk_b("ar_no_stale", issue_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
